// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
//   Bundles the CPU load/store port, the host/debug loader port and the
//   data-memory port of the arbiter.
//   slave  : arbiter view (takes requests and mem_rdata; drives grants,
//            rvalids, lock_abort, memory controls and rdata)
//   master : requester/memory view (mirror of slave)
interface dmem_arbiter_if;
  // CPU port
  logic        cpu_req;
  logic        cpu_wr;
  logic [7:0]  cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_gnt;
  logic        cpu_stall;
  logic        cpu_rvalid;
  // Host port
  logic        host_req;
  logic        host_wr;
  logic [7:0]  host_addr;
  logic [15:0] host_wdata;
  logic        host_lock;
  logic        host_gnt;
  logic        host_rvalid;
  logic        lock_abort;
  // Memory port
  logic [7:0]  mem_addr;
  logic        mem_wr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [15:0] rdata;

  modport slave (
    input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    input  host_req, host_wr, host_addr, host_wdata, host_lock,
    input  mem_rdata,
    output cpu_gnt, cpu_stall, cpu_rvalid,
    output host_gnt, host_rvalid, lock_abort,
    output mem_addr, mem_wr, mem_wdata, rdata
  );

  modport master (
    output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    output host_req, host_wr, host_addr, host_wdata, host_lock,
    output mem_rdata,
    input  cpu_gnt, cpu_stall, cpu_rvalid,
    input  host_gnt, host_rvalid, lock_abort,
    input  mem_addr, mem_wr, mem_wdata, rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single-port 256x16 data memory between the CPU (fixed
//   priority) and the host loader. A wait counter forces a host grant after
//   HOST_MAX_WAIT denied cycles; a host lock gives the host exclusive use
//   for at most LOCK_MAX cycles.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : dmem_arbiter_if.slave (CPU, host and memory ports)
module dmem_arbiter #(
  parameter int unsigned HOST_MAX_WAIT = 4,
  parameter int unsigned LOCK_MAX      = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic {ARB, HOST_LOCK} state_e;

  localparam logic [3:0] WAIT_MAX = 4'(HOST_MAX_WAIT);
  localparam logic [7:0] LOCK_LIM = 8'(LOCK_MAX);

  state_e      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [7:0]  lock_cnt_q, lock_cnt_d;
  logic        lock_abort_q, lock_abort_d;
  logic        cpu_rvalid_q, host_rvalid_q;
  logic        cpu_gnt, host_gnt;

  always_comb begin
    state_d      = state_q;
    lock_cnt_d   = lock_cnt_q;
    lock_abort_d = 1'b0;
    cpu_gnt      = 1'b0;
    host_gnt     = 1'b0;
    unique case (state_q)
      ARB: begin
        if (bus.host_req && (wait_cnt_q == WAIT_MAX)) host_gnt = 1'b1;
        else if (bus.cpu_req)                         cpu_gnt  = 1'b1;
        else if (bus.host_req)                        host_gnt = 1'b1;
        if (host_gnt && bus.host_lock) begin
          state_d    = HOST_LOCK;
          lock_cnt_d = 8'd1;
        end
      end
      HOST_LOCK: begin
        host_gnt = bus.host_req;
        // A voluntary release takes precedence, so no abort pulse when the
        // host drops host_lock on the final permitted cycle.
        if (!bus.host_lock) begin
          state_d    = ARB;
          lock_cnt_d = '0;
        end else if (lock_cnt_q == LOCK_LIM) begin
          state_d      = ARB;
          lock_cnt_d   = '0;
          lock_abort_d = 1'b1;
        end else if (lock_cnt_q != '1) begin
          lock_cnt_d = lock_cnt_q + 8'd1;
        end
      end
      default: state_d = ARB;
    endcase
    // Grants are held off for the whole time reset is asserted.
    if (!rst_n) begin
      cpu_gnt  = 1'b0;
      host_gnt = 1'b0;
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!bus.host_req || host_gnt) wait_cnt_d = '0;
    else if (wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ARB;
      wait_cnt_q    <= '0;
      lock_cnt_q    <= '0;
      lock_abort_q  <= 1'b0;
      cpu_rvalid_q  <= 1'b0;
      host_rvalid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      lock_cnt_q    <= lock_cnt_d;
      lock_abort_q  <= lock_abort_d;
      cpu_rvalid_q  <= cpu_gnt & ~bus.cpu_wr;
      host_rvalid_q <= host_gnt & ~bus.host_wr;
    end
  end

  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wr    = 1'b0;
    bus.mem_wdata = '0;
    if (cpu_gnt) begin
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wr    = bus.cpu_wr;
      bus.mem_wdata = bus.cpu_wdata;
    end else if (host_gnt) begin
      bus.mem_addr  = bus.host_addr;
      bus.mem_wr    = bus.host_wr;
      bus.mem_wdata = bus.host_wdata;
    end
  end

  assign bus.cpu_gnt     = cpu_gnt;
  assign bus.cpu_stall   = bus.cpu_req & ~cpu_gnt;
  assign bus.cpu_rvalid  = cpu_rvalid_q;
  assign bus.host_gnt    = host_gnt;
  assign bus.host_rvalid = host_rvalid_q;
  assign bus.lock_abort  = lock_abort_q;
  assign bus.rdata       = bus.mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Directed stimulus for dmem_arbiter with a scoreboard: expected grants,
//   read returns and abort pulses are queued with their cycle stamp and a
//   negedge monitor pops and compares whenever the DUT presents one.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   sb_on = 1'b0;

  typedef struct {
    int          cyc;
    logic        port;   // 0 = CPU, 1 = host
    logic        wr;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic        stall;
  } gnt_t;

  typedef struct {
    int          cyc;
    logic        port;
    logic [15:0] data;
  } rd_t;

  gnt_t gq[$];
  rd_t  rq[$];
  int   aq[$];
  gnt_t mg;
  rd_t  mr;
  int   ma;

  logic [15:0] mem [256];

  dmem_arbiter_if bus();

  dmem_arbiter #(.HOST_MAX_WAIT(4), .LOCK_MAX(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read memory, one cycle latency.
  always @(posedge clk) begin
    if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [7:0] ca, input logic [15:0] cd,
                       input logic hr, input logic hw, input logic [7:0] ha, input logic [15:0] hd,
                       input logic hl);
    @(posedge clk);
    #1;
    bus.cpu_req = cr; bus.cpu_wr = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
    bus.host_req = hr; bus.host_wr = hw; bus.host_addr = ha; bus.host_wdata = hd;
    bus.host_lock = hl;
  endtask

  task automatic idle();
    drive(0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0, 0);
  endtask

  task automatic exp_gnt(input logic port, input logic wr, input logic [7:0] addr,
                         input logic [15:0] wdata, input logic stall);
    gq.push_back('{cyc, port, wr, addr, wdata, stall});
  endtask

  task automatic exp_rd(input logic port, input logic [15:0] data);
    rq.push_back('{cyc + 1, port, data});
  endtask

  task automatic reset_check(input string name);
    check(name, 64'({bus.cpu_gnt, bus.host_gnt, bus.mem_wr, bus.cpu_rvalid,
                     bus.host_rvalid, bus.lock_abort, bus.mem_addr}), 64'(0));
  endtask

  always @(negedge clk) begin
    if (rst_n && sb_on) begin
      if (bus.cpu_gnt || bus.host_gnt) begin
        if (gq.size() == 0) check("gnt_unexpected", 64'({bus.cpu_gnt, bus.host_gnt}), 64'(0));
        else begin
          mg = gq.pop_front();
          check("gnt", 64'({16'(cyc), bus.cpu_gnt, bus.host_gnt, bus.mem_wr, bus.mem_addr,
                            bus.mem_wdata, bus.cpu_stall}),
                       64'({16'(mg.cyc), ~mg.port, mg.port, mg.wr, mg.addr, mg.wdata, mg.stall}));
        end
      end else begin
        check("idle_bus", 64'({bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.cpu_stall}),
                          64'({1'b0, 8'h00, 16'h0000, bus.cpu_req}));
      end
      if (bus.cpu_rvalid || bus.host_rvalid) begin
        if (rq.size() == 0) check("rvalid_unexpected", 64'({bus.cpu_rvalid, bus.host_rvalid}), 64'(0));
        else begin
          mr = rq.pop_front();
          check("rvalid", 64'({16'(cyc), bus.cpu_rvalid, bus.host_rvalid, bus.rdata}),
                          64'({16'(mr.cyc), ~mr.port, mr.port, mr.data}));
        end
      end
      if (bus.lock_abort) begin
        if (aq.size() == 0) check("abort_unexpected", 64'(bus.lock_abort), 64'(0));
        else begin
          ma = aq.pop_front();
          check("lock_abort", 64'(cyc), 64'(ma));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.cpu_req = 1; bus.cpu_wr = 1; bus.cpu_addr = 8'h33; bus.cpu_wdata = 16'h5555;
    bus.host_req = 1; bus.host_wr = 1; bus.host_addr = 8'h44; bus.host_wdata = 16'hAAAA;
    bus.host_lock = 1;
    repeat (2) @(negedge clk);
    reset_check("reset_outputs");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.cpu_req = 0; bus.cpu_wr = 0; bus.host_req = 0; bus.host_wr = 0; bus.host_lock = 0;
    sb_on = 1'b1;

    // Preload via host-only writes (no contention -> immediate grant).
    drive(0, 0, 8'h00, 16'h0, 1, 1, 8'h10, 16'hBEEF, 0); exp_gnt(1, 1, 8'h10, 16'hBEEF, 0);
    idle();

    // CPU-only read of 0x10.
    drive(1, 0, 8'h10, 16'h0, 0, 0, 8'h00, 16'h0, 0); exp_gnt(0, 0, 8'h10, 16'h0, 0); exp_rd(0, 16'hBEEF);
    idle();

    // Contention: host forced in after 4 denied cycles, writes 0x1234 to 0x20.
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 8'h10, 16'h0, (i <= 4), 1, 8'h20, 16'h1234, 0);
      if (i == 4) exp_gnt(1, 1, 8'h20, 16'h1234, 1);
      else begin exp_gnt(0, 0, 8'h10, 16'h0, 0); exp_rd(0, 16'hBEEF); end
    end
    idle();

    // CPU reads the host-written word; then host-only read.
    drive(1, 0, 8'h20, 16'h0, 0, 0, 8'h00, 16'h0, 0); exp_gnt(0, 0, 8'h20, 16'h0, 0); exp_rd(0, 16'h1234);
    drive(0, 0, 8'h00, 16'h0, 1, 0, 8'h20, 16'h0, 0); exp_gnt(1, 0, 8'h20, 16'h0, 0); exp_rd(1, 16'h1234);
    idle();

    // Voluntary lock: host forced in at cycle 4 with lock, 3 writes, release.
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 8'h10, 16'h0, 1, 1, 8'h50, 16'hA001, 1);
      exp_gnt(0, 0, 8'h10, 16'h0, 0); exp_rd(0, 16'hBEEF);
    end
    drive(1, 0, 8'h10, 16'h0, 1, 1, 8'h50, 16'hA001, 1); exp_gnt(1, 1, 8'h50, 16'hA001, 1);
    drive(1, 0, 8'h10, 16'h0, 1, 1, 8'h51, 16'hA002, 1); exp_gnt(1, 1, 8'h51, 16'hA002, 1);
    drive(1, 0, 8'h10, 16'h0, 1, 1, 8'h52, 16'hA003, 1); exp_gnt(1, 1, 8'h52, 16'hA003, 1);
    drive(1, 0, 8'h10, 16'h0, 0, 0, 8'h00, 16'h0, 0);    // still locked: CPU stalled, no grant
    drive(1, 0, 8'h10, 16'h0, 0, 0, 8'h00, 16'h0, 0); exp_gnt(0, 0, 8'h10, 16'h0, 0); exp_rd(0, 16'hBEEF);
    drive(1, 0, 8'h51, 16'h0, 0, 0, 8'h00, 16'h0, 0); exp_gnt(0, 0, 8'h51, 16'h0, 0); exp_rd(0, 16'hA002);
    idle();

    // Forced release after 16 lock cycles.
    drive(0, 0, 8'h10, 16'h0, 1, 0, 8'h10, 16'h0, 1); exp_gnt(1, 0, 8'h10, 16'h0, 0); exp_rd(1, 16'hBEEF);
    for (int i = 1; i <= 16; i++) begin
      drive(1, 0, 8'h10, 16'h0, 1, 0, 8'h10, 16'h0, 1); exp_gnt(1, 0, 8'h10, 16'h0, 1); exp_rd(1, 16'hBEEF);
    end
    drive(1, 0, 8'h10, 16'h0, 0, 0, 8'h00, 16'h0, 0);
    exp_gnt(0, 0, 8'h10, 16'h0, 0); exp_rd(0, 16'hBEEF); aq.push_back(cyc);
    idle();

    // Reset mid-lock with a host read just granted.
    drive(0, 0, 8'h00, 16'h0, 1, 0, 8'h20, 16'h0, 1); exp_gnt(1, 0, 8'h20, 16'h0, 0); exp_rd(1, 16'h1234);
    drive(1, 0, 8'h10, 16'h0, 1, 0, 8'h20, 16'h0, 1); exp_gnt(1, 0, 8'h20, 16'h0, 1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    reset_check("reset_midlock");
    drive(1, 0, 8'h10, 16'h0, 1, 0, 8'h20, 16'h0, 0);
    rst_n = 1'b1;
    exp_gnt(0, 0, 8'h10, 16'h0, 0); exp_rd(0, 16'hBEEF);
    drive(0, 0, 8'h00, 16'h0, 1, 0, 8'h20, 16'h0, 0); exp_gnt(1, 0, 8'h20, 16'h0, 0); exp_rd(1, 16'h1234);
    repeat (3) idle();
    @(negedge clk);
    #1;
    sb_on = 1'b0;

    check("gnt_queue_drained", 64'(gq.size()), 64'(0));
    check("rvalid_queue_drained", 64'(rq.size()), 64'(0));
    check("abort_queue_drained", 64'(aq.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
